// File: rtl/dvp_cap_pkg.sv
// Shared state encoding and default buffer geometry for the DVP frame-capture sequencer.
package dvp_cap_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARM       = 2'd1,
    CAPTURE   = 2'd2,
    WAIT_DONE = 2'd3
  } cap_state_t;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'h1034_5688;
  localparam logic [31:0] DEF_FRAME_BYTES = 32'h0012_C000;

endpackage

// File: rtl/dvp_buf_ring.sv
// N-entry DDR3 frame buffer ring: current index and its base address, stepped once per completed frame.
module dvp_buf_ring #(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = 32'h1034_5688,
  parameter logic [ADDRESS_WIDTH-1:0] FRAME_BYTES   = 32'h0012_C000,
  parameter int unsigned              NUM_BUFFERS   = 2,
  parameter int unsigned              BUF_IDX_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     step,
  output logic [BUF_IDX_WIDTH-1:0] buf_idx,
  output logic [ADDRESS_WIDTH-1:0] buf_base
);

  localparam logic [BUF_IDX_WIDTH-1:0] LAST_IDX = BUF_IDX_WIDTH'(NUM_BUFFERS - 1);

  // Base is accumulated alongside the index so no multiplier is needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_idx  <= '0;
      buf_base <= BASE_ADDR;
    end else if (step) begin
      if (buf_idx == LAST_IDX) begin
        buf_idx  <= '0;
        buf_base <= BASE_ADDR;
      end else begin
        buf_idx  <= buf_idx + 1'b1;
        buf_base <= buf_base + FRAME_BYTES;
      end
    end
  end

endmodule

// File: rtl/dvp_frame_capture_ctrl.sv
// Frame-capture sequencer between the DVP/RGB888 path and the ddr3_write master.
// Optional capture watchdog enabled by defining DVP_CAP_TIMEOUT_EN.
module dvp_frame_capture_ctrl
  import dvp_cap_pkg::*;
#(
  parameter int unsigned              ADDRESS_WIDTH   = 32,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR       = DEF_BASE_ADDR,
  parameter logic [ADDRESS_WIDTH-1:0] FRAME_BYTES     = DEF_FRAME_BYTES,
  parameter int unsigned              NUM_BUFFERS     = 2,
  parameter int unsigned              BUF_IDX_WIDTH   = 4,
  parameter int unsigned              FRAME_CNT_WIDTH = 8
`ifdef DVP_CAP_TIMEOUT_EN
  , parameter logic [23:0]            TIMEOUT_CYCLES  = 24'd2000000
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_start,
  input  logic                       cmd_stop,
  input  logic                       cmd_continuous,
  input  logic [FRAME_CNT_WIDTH-1:0] frame_target,
  input  logic                       vsync_begin,
  input  logic                       vsync_end,
  input  logic                       control_done,
  output logic                       control_go,
  output logic [ADDRESS_WIDTH-1:0]   control_write_base,
  output logic [ADDRESS_WIDTH-1:0]   control_write_length,
  output logic                       capture_en,
  output logic                       busy,
  output logic [BUF_IDX_WIDTH-1:0]   last_buf_idx,
  output logic [FRAME_CNT_WIDTH-1:0] frames_done,
  output logic [FRAME_CNT_WIDTH-1:0] frames_dropped,
`ifdef DVP_CAP_TIMEOUT_EN
  output logic                       timeout_err,
`endif
  output logic                       frame_valid
);

  cap_state_t                 state;
  logic                       cont_mode;
  logic [FRAME_CNT_WIDTH-1:0] frame_tgt;
  logic                       stop_pending;
  logic                       done_low_seen;
  logic                       done_evt;
  logic [BUF_IDX_WIDTH-1:0]   buf_idx;

  function automatic logic [FRAME_CNT_WIDTH-1:0] sat_inc(input logic [FRAME_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A done level only counts once the writer has been seen busy after our go.
  assign done_evt             = (state == WAIT_DONE) && control_done && done_low_seen;
  assign busy                 = (state != IDLE);
  assign control_write_length = FRAME_BYTES;

`ifdef DVP_CAP_TIMEOUT_EN
  logic [23:0] to_cnt;
  logic        timeout_hit;
  assign timeout_hit = ((state == CAPTURE) || (state == WAIT_DONE)) &&
                       (to_cnt == TIMEOUT_CYCLES - 24'd1);
`endif

  dvp_buf_ring #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .BASE_ADDR     (BASE_ADDR),
    .FRAME_BYTES   (FRAME_BYTES),
    .NUM_BUFFERS   (NUM_BUFFERS),
    .BUF_IDX_WIDTH (BUF_IDX_WIDTH)
  ) u_ring (
    .clk      (clk),
    .reset    (reset),
    .step     (done_evt),
    .buf_idx  (buf_idx),
    .buf_base (control_write_base)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cont_mode      <= 1'b0;
      frame_tgt      <= '0;
      stop_pending   <= 1'b0;
      done_low_seen  <= 1'b0;
      control_go     <= 1'b0;
      capture_en     <= 1'b0;
      frame_valid    <= 1'b0;
      last_buf_idx   <= '0;
      frames_done    <= '0;
      frames_dropped <= '0;
`ifdef DVP_CAP_TIMEOUT_EN
      to_cnt         <= '0;
      timeout_err    <= 1'b0;
`endif
    end else begin
      control_go  <= 1'b0;
      frame_valid <= 1'b0;
      if ((state != IDLE) && cmd_stop)
        stop_pending <= 1'b1;
      if (((state == CAPTURE) || (state == WAIT_DONE)) && !control_done)
        done_low_seen <= 1'b1;
`ifdef DVP_CAP_TIMEOUT_EN
      to_cnt <= ((state == CAPTURE) || (state == WAIT_DONE)) ? to_cnt + 24'd1 : 24'd0;
`endif
      case (state)
        IDLE: begin
          if (cmd_start) begin
            cont_mode      <= cmd_continuous;
            frame_tgt      <= (frame_target == '0) ? FRAME_CNT_WIDTH'(1) : frame_target;
            frames_done    <= '0;
            frames_dropped <= '0;
`ifdef DVP_CAP_TIMEOUT_EN
            timeout_err    <= 1'b0;
`endif
            state          <= ARM;
          end
        end
        ARM: begin
          if (cmd_stop || stop_pending) begin
            stop_pending <= 1'b0;
            state        <= IDLE;
          end else if (vsync_end) begin
            control_go    <= 1'b1;
            capture_en    <= 1'b1;
            done_low_seen <= 1'b0;
            state         <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (vsync_begin) begin
            capture_en <= 1'b0;
            state      <= WAIT_DONE;
`ifdef DVP_CAP_TIMEOUT_EN
            to_cnt     <= '0;
`endif
          end
        end
        WAIT_DONE: begin
          // Any frame start seen here could not be captured, even when done arrives alongside it.
          if (vsync_end)
            frames_dropped <= sat_inc(frames_dropped);
          if (done_evt) begin
            frame_valid  <= 1'b1;
            last_buf_idx <= buf_idx;
            frames_done  <= frames_done + 1'b1;
            if (stop_pending || cmd_stop ||
                (!cont_mode && ((frames_done + 1'b1) == frame_tgt))) begin
              stop_pending <= 1'b0;
              state        <= IDLE;
            end else begin
              state <= ARM;
            end
          end
        end
        default: state <= IDLE;
      endcase
`ifdef DVP_CAP_TIMEOUT_EN
      if (timeout_hit) begin
        capture_en   <= 1'b0;
        timeout_err  <= 1'b1;
        stop_pending <= 1'b0;
        state        <= IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dvp_frame_capture_ctrl.sv
// Randomized scenario bench for dvp_frame_capture_ctrl with a ring-position/frame-count reference model.
module tb_dvp_frame_capture_ctrl;

  localparam logic [31:0] BASE = 32'h1034_5688;
  localparam logic [31:0] FB   = 32'h0012_C000;
  localparam int          NB   = 3;

  logic        clk = 1'b0, reset = 1'b1;
  logic        cmd_start = 1'b0, cmd_stop = 1'b0, cmd_continuous = 1'b0;
  logic [7:0]  frame_target = 8'd0;
  logic        vsync_begin = 1'b0, vsync_end = 1'b0, control_done = 1'b1;
  logic        control_go, capture_en, busy, frame_valid;
  logic [31:0] control_write_base, control_write_length;
  logic [3:0]  last_buf_idx;
  logic [7:0]  frames_done, frames_dropped;
`ifdef DVP_CAP_TIMEOUT_EN
  logic        timeout_err;
`endif

  int          n_cmp = 0, n_err = 0;
  int          go_cnt = 0, fv_cnt = 0;
  logic [31:0] go_bases[$];
  int          m_idx = 0;

  dvp_frame_capture_ctrl #(
    .NUM_BUFFERS (NB)
`ifdef DVP_CAP_TIMEOUT_EN
    , .TIMEOUT_CYCLES (24'd100)
`endif
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .cmd_start            (cmd_start),
    .cmd_stop             (cmd_stop),
    .cmd_continuous       (cmd_continuous),
    .frame_target         (frame_target),
    .vsync_begin          (vsync_begin),
    .vsync_end            (vsync_end),
    .control_done         (control_done),
    .control_go           (control_go),
    .control_write_base   (control_write_base),
    .control_write_length (control_write_length),
    .capture_en           (capture_en),
    .busy                 (busy),
    .last_buf_idx         (last_buf_idx),
    .frames_done          (frames_done),
    .frames_dropped       (frames_dropped),
`ifdef DVP_CAP_TIMEOUT_EN
    .timeout_err          (timeout_err),
`endif
    .frame_valid          (frame_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (control_go) begin
      go_cnt++;
      go_bases.push_back(control_write_base);
    end
    if (frame_valid) fv_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_base(input int idx);
    return BASE + FB * 32'(idx);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_vend();
    vsync_end = 1'b1; tick(); vsync_end = 1'b0;
  endtask

  task automatic pulse_vbeg();
    vsync_begin = 1'b1; tick(); vsync_begin = 1'b0;
  endtask

  task automatic pulse_stop();
    cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
  endtask

  task automatic start(input logic cont, input logic [7:0] tgt);
    cmd_continuous = cont; frame_target = tgt;
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
    m_idx = 0;
  endtask

  // One frame as seen from the sensor and writer; extra vsync_end pulses arrive while the writer is busy.
  task automatic do_frame(input int drops);
    repeat ($urandom_range(4, 1)) tick();
    pulse_vend(); control_done = 1'b0;
    repeat ($urandom_range(6, 2)) tick();
    pulse_vbeg();
    for (int d = 0; d < drops; d++) begin
      repeat ($urandom_range(3, 1)) tick();
      pulse_vend();
    end
    repeat ($urandom_range(3, 1)) tick();
    control_done = 1'b1; tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    n_cmp++; if (control_go !== 1'b0) begin n_err++; $display("FAIL rst_go: got %b want 0", control_go); end
    n_cmp++; if (control_write_base !== BASE) begin n_err++; $display("FAIL rst_base: got %h want %h", control_write_base, BASE); end
    n_cmp++; if (control_write_length !== FB) begin n_err++; $display("FAIL rst_len: got %h want %h", control_write_length, FB); end
    n_cmp++; if (capture_en !== 1'b0) begin n_err++; $display("FAIL rst_cap: got %b want 0", capture_en); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (frames_done !== 8'd0) begin n_err++; $display("FAIL rst_done: got %0d want 0", frames_done); end
    n_cmp++; if (frames_dropped !== 8'd0) begin n_err++; $display("FAIL rst_drop: got %0d want 0", frames_dropped); end
    n_cmp++; if (last_buf_idx !== 4'd0) begin n_err++; $display("FAIL rst_last: got %0d want 0", last_buf_idx); end
    n_cmp++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL rst_fv: got %b want 0", frame_valid); end
    reset = 1'b0; tick();
    m_idx = 0;
  endtask

  task automatic test_single_shot();
    int g0;
    g0 = go_cnt;
    start(1'b0, 8'd1);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ss_busy_arm: got %b want 1", busy); end
    repeat ($urandom_range(5, 1)) tick();
    n_cmp++; if (go_cnt !== g0) begin n_err++; $display("FAIL ss_early_go: got %0d want %0d", go_cnt, g0); end
    pulse_vend();
    n_cmp++; if (control_go !== 1'b1) begin n_err++; $display("FAIL ss_go: got %b want 1", control_go); end
    n_cmp++; if (control_write_base !== exp_base(m_idx)) begin n_err++; $display("FAIL ss_base: got %h want %h", control_write_base, exp_base(m_idx)); end
    n_cmp++; if (capture_en !== 1'b1) begin n_err++; $display("FAIL ss_cap_on: got %b want 1", capture_en); end
    tick(); control_done = 1'b0;
    n_cmp++; if (control_go !== 1'b0) begin n_err++; $display("FAIL ss_go_pulse: got %b want 0", control_go); end
    repeat ($urandom_range(6, 2)) tick();
    n_cmp++; if (capture_en !== 1'b1) begin n_err++; $display("FAIL ss_cap_hold: got %b want 1", capture_en); end
    pulse_vbeg();
    n_cmp++; if (capture_en !== 1'b0) begin n_err++; $display("FAIL ss_cap_off: got %b want 0", capture_en); end
    repeat ($urandom_range(4, 1)) tick();
    control_done = 1'b1; tick();
    n_cmp++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL ss_fv: got %b want 1", frame_valid); end
    n_cmp++; if (frames_done !== 8'd1) begin n_err++; $display("FAIL ss_frames: got %0d want 1", frames_done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ss_idle: got %b want 0", busy); end
    n_cmp++; if (last_buf_idx !== 4'(m_idx)) begin n_err++; $display("FAIL ss_last: got %0d want %0d", last_buf_idx, m_idx); end
    m_idx = (m_idx + 1) % NB;
    tick();
    n_cmp++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL ss_fv_pulse: got %b want 0", frame_valid); end
    n_cmp++; if (go_cnt !== g0 + 1) begin n_err++; $display("FAIL ss_go_count: got %0d want %0d", go_cnt - g0, 1); end
  endtask

  task automatic test_ring_wrap();
    logic [31:0] plan [4];
    int k0, g0;
    plan = '{32'h1034_5688, 32'h1047_1688, 32'h1059_D688, 32'h1034_5688};
    apply_reset();
    k0 = go_bases.size(); g0 = go_cnt;
    start(1'b0, 8'd4);
    for (int f = 0; f < 4; f++) do_frame(0);
    tick();
    n_cmp++; if (go_cnt - g0 !== 4) begin n_err++; $display("FAIL ring_go_count: got %0d want 4", go_cnt - g0); end
    for (int i = 0; i < 4 && k0 + i < go_bases.size(); i++) begin
      n_cmp++; if (go_bases[k0+i] !== plan[i]) begin n_err++; $display("FAIL ring_base%0d: got %h want %h", i, go_bases[k0+i], plan[i]); end
    end
    n_cmp++; if (frames_done !== 8'd4) begin n_err++; $display("FAIL ring_frames: got %0d want 4", frames_done); end
    n_cmp++; if (last_buf_idx !== 4'd0) begin n_err++; $display("FAIL ring_last: got %0d want 0", last_buf_idx); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ring_idle: got %b want 0", busy); end
    m_idx = 4 % NB;
  endtask

  task automatic test_overrun();
    int g0;
    start(1'b1, 8'd0);
    g0 = go_cnt;
    pulse_vend(); control_done = 1'b0;
    repeat (3) tick();
    pulse_vbeg();
    repeat (2) begin repeat (2) tick(); pulse_vend(); end
    tick();
    n_cmp++; if (frames_dropped !== 8'd2) begin n_err++; $display("FAIL ovr_dropped: got %0d want 2", frames_dropped); end
    n_cmp++; if (go_cnt !== g0 + 1) begin n_err++; $display("FAIL ovr_extra_go: got %0d want %0d", go_cnt - g0, 1); end
    control_done = 1'b1; tick();
    n_cmp++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL ovr_fv: got %b want 1", frame_valid); end
    m_idx = (m_idx + 1) % NB;
    tick();
    n_cmp++; if ({busy, capture_en, control_go} !== 3'b100) begin n_err++; $display("FAIL ovr_arm: got %b want 100", {busy, capture_en, control_go}); end
    pulse_vend();
    n_cmp++; if (control_write_base !== exp_base(m_idx)) begin n_err++; $display("FAIL ovr_next_base: got %h want %h", control_write_base, exp_base(m_idx)); end
    control_done = 1'b0; repeat (2) tick(); pulse_vbeg(); tick();
    control_done = 1'b1; tick();
    m_idx = (m_idx + 1) % NB;
    pulse_stop();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovr_stop: got %b want 0", busy); end
  endtask

  task automatic test_continuous_stop();
    int nf, drops, k0, g0, d;
    logic [31:0] exp_q[$];
    drops = 0; k0 = go_bases.size();
    start(1'b1, 8'd0);
    nf = $urandom_range(3, 1);
    for (int f = 0; f < nf; f++) begin
      d = $urandom_range(1, 0); drops += d;
      exp_q.push_back(exp_base(m_idx)); m_idx = (m_idx + 1) % NB;
      do_frame(d);
    end
    exp_q.push_back(exp_base(m_idx));
    pulse_vend(); control_done = 1'b0;
    repeat (2) tick();
    pulse_stop();
    n_cmp++; if ({busy, capture_en} !== 2'b11) begin n_err++; $display("FAIL cs_mid_capture: got %b want 11", {busy, capture_en}); end
    repeat (2) tick(); pulse_vbeg(); repeat (2) tick();
    control_done = 1'b1; tick();
    n_cmp++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL cs_fv: got %b want 1", frame_valid); end
    n_cmp++; if (frames_done !== 8'(nf + 1)) begin n_err++; $display("FAIL cs_frames: got %0d want %0d", frames_done, nf + 1); end
    n_cmp++; if (frames_dropped !== 8'(drops)) begin n_err++; $display("FAIL cs_dropped: got %0d want %0d", frames_dropped, drops); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL cs_idle: got %b want 0", busy); end
    m_idx = (m_idx + 1) % NB;
    tick();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (k0 + i >= go_bases.size() || go_bases[k0+i] !== exp_q[i]) begin n_err++; $display("FAIL cs_base%0d: got %h want %h", i, (k0 + i < go_bases.size()) ? go_bases[k0+i] : 32'hx, exp_q[i]); end
    end
    g0 = go_cnt;
    start(1'b1, 8'd0);
    repeat ($urandom_range(4, 1)) tick();
    pulse_stop();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL cs_arm_stop: got %b want 0", busy); end
    repeat (3) tick();
    n_cmp++; if (go_cnt !== g0) begin n_err++; $display("FAIL cs_arm_nogo: got %0d want %0d", go_cnt, g0); end
  endtask

  task automatic test_collision();
    start(1'b1, 8'd0);
    pulse_vend(); control_done = 1'b0;
    repeat (2) tick(); pulse_vbeg(); repeat (2) tick();
    control_done = 1'b1; vsync_end = 1'b1; tick(); vsync_end = 1'b0;
    n_cmp++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL col_fv: got %b want 1", frame_valid); end
    n_cmp++; if (frames_dropped !== 8'd1) begin n_err++; $display("FAIL col_dropped: got %0d want 1", frames_dropped); end
    n_cmp++; if ({busy, capture_en} !== 2'b10) begin n_err++; $display("FAIL col_arm: got %b want 10", {busy, capture_en}); end
    m_idx = (m_idx + 1) % NB;
    tick();
    n_cmp++; if (control_go !== 1'b0) begin n_err++; $display("FAIL col_nogo: got %b want 0", control_go); end
    pulse_stop();
  endtask

  task automatic test_reset_mid_capture();
    start(1'b1, 8'd0);
    do_frame(1);
    pulse_vend();
    repeat (2) tick();
    n_cmp++; if (capture_en !== 1'b1) begin n_err++; $display("FAIL rm_pre_cap: got %b want 1", capture_en); end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (capture_en !== 1'b0) begin n_err++; $display("FAIL rm_cap_async: got %b want 0", capture_en); end
    n_cmp++; if ({busy, control_go, frame_valid} !== 3'b000) begin n_err++; $display("FAIL rm_ctrl: got %b want 000", {busy, control_go, frame_valid}); end
    n_cmp++; if (control_write_base !== BASE) begin n_err++; $display("FAIL rm_base: got %h want %h", control_write_base, BASE); end
    n_cmp++; if ({frames_done, frames_dropped, last_buf_idx} !== 20'd0) begin n_err++; $display("FAIL rm_counts: got %h want 0", {frames_done, frames_dropped, last_buf_idx}); end
    control_done = 1'b1;
    tick(); reset = 1'b0; tick();
    m_idx = 0;
  endtask

  task automatic test_random_counted();
    int tgt, eff, drops, d, k0, g0, last;
    logic [31:0] exp_q[$];
    for (int r = 0; r < 4; r++) begin
      tgt = $urandom_range(5, 0); eff = (tgt == 0) ? 1 : tgt;
      drops = 0; k0 = go_bases.size(); g0 = go_cnt; exp_q.delete();
      start(1'b0, 8'(tgt));
      for (int f = 0; f < eff; f++) begin
        d = $urandom_range(2, 0); drops += d;
        exp_q.push_back(exp_base(m_idx)); last = m_idx; m_idx = (m_idx + 1) % NB;
        do_frame(d);
      end
      tick();
      n_cmp++; if (frames_done !== 8'(eff)) begin n_err++; $display("FAIL rnd%0d_frames: got %0d want %0d", r, frames_done, eff); end
      n_cmp++; if (frames_dropped !== 8'(drops)) begin n_err++; $display("FAIL rnd%0d_dropped: got %0d want %0d", r, frames_dropped, drops); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rnd%0d_idle: got %b want 0", r, busy); end
      n_cmp++; if (go_cnt - g0 !== eff) begin n_err++; $display("FAIL rnd%0d_go_count: got %0d want %0d", r, go_cnt - g0, eff); end
      n_cmp++; if (last_buf_idx !== 4'(last)) begin n_err++; $display("FAIL rnd%0d_last: got %0d want %0d", r, last_buf_idx, last); end
      for (int i = 0; i < eff && k0 + i < go_bases.size(); i++) begin
        n_cmp++; if (go_bases[k0+i] !== exp_q[i]) begin n_err++; $display("FAIL rnd%0d_base%0d: got %h want %h", r, i, go_bases[k0+i], exp_q[i]); end
      end
    end
  endtask

`ifdef DVP_CAP_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    start(1'b1, 8'd0);
    pulse_vend();
    n = 0;
    while (busy && n < 200) begin tick(); n++; end
    n_cmp++; if (n !== 100) begin n_err++; $display("FAIL to_cycles: got %0d want 100", n); end
    n_cmp++; if ({timeout_err, capture_en, busy} !== 3'b100) begin n_err++; $display("FAIL to_state: got %b want 100", {timeout_err, capture_en, busy}); end
    start(1'b1, 8'd0);
    n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_clear: got %b want 0", timeout_err); end
    pulse_stop();
  endtask
`endif

  initial begin
    test_reset();
    test_single_shot();
    test_ring_wrap();
    test_overrun();
    test_continuous_stop();
    test_collision();
    test_reset_mid_capture();
    test_random_counted();
`ifdef DVP_CAP_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
